// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and word helpers.
// Purely combinational helpers; no latency of their own.
// No flow control here; callers own all handshaking.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] round_key_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } ks_state_e;

    // Round constants sit in the most significant byte of the word,
    // which is the byte RotWord moved out of position 0.
    localparam logic [31:0] RCON [1:10] = '{
        32'h0100_0000, 32'h0200_0000, 32'h0400_0000, 32'h0800_0000,
        32'h1000_0000, 32'h2000_0000, 32'h4000_0000, 32'h8000_0000,
        32'h1b00_0000, 32'h3600_0000
    };

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Out-of-range indices give zero so an idle counter never selects X.
    function automatic logic [31:0] rcon_of(input logic [3:0] r);
        logic [31:0] v;
        v = 32'h0;
        if (r >= 4'd1 && r <= 4'd10) v = RCON[r];
        return v;
    endfunction

    // Entry b occupies bits [2047-8b -: 8]; 2047-8b == {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/key_schedule_rev_if.sv
// Key-in / round-key-out bundle between the inverse cipher and its key source.
// Signals only; latency is defined by the block using the slave modport.
// key_* is valid/ready into the block, rk_* is valid/ready out of it.
interface key_schedule_rev_if;
    import aes_pkg::*;

    logic       key_valid;
    logic       key_ready;
    round_key_t key_in;
    logic       rk_valid;
    logic       rk_ready;
    round_key_t rk_data;
    logic [3:0] rk_round;
    logic       rk_last;
    logic       busy;

    // master: key source / round-key consumer side
    modport master (
        output key_valid, key_in, rk_ready,
        input  key_ready, rk_valid, rk_data, rk_round, rk_last, busy
    );

    // slave: the reverse key schedule itself
    modport slave (
        input  key_valid, key_in, rk_ready,
        output key_ready, rk_valid, rk_data, rk_round, rk_last, busy
    );
endinterface

// File: rtl/inv_key_step.sv
// One inverse AES-128 key-expansion step: round key r -> round key r-1.
// Combinational, zero latency.
// No flow control; ports: key_in (round r), rcon (rcon[r]), key_out.
module inv_key_step
    import aes_pkg::*;
(
    input  round_key_t  key_in,
    input  logic [31:0] rcon,
    output round_key_t  key_out
);
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] o0, o1, o2, o3;

    assign p0 = key_in[31:0];
    assign p1 = key_in[63:32];
    assign p2 = key_in[95:64];
    assign p3 = key_in[127:96];

    // Undo the XOR chain first; the recovered w3 then feeds the
    // SubWord/RotWord term that reverses word 0.
    assign o3 = p3 ^ p2;
    assign o2 = p2 ^ p1;
    assign o1 = p1 ^ p0;
    assign o0 = p0 ^ rcon ^ sub_word(rot_word(o3));

    assign key_out = {o3, o2, o1, o0};
endmodule

// File: rtl/key_schedule.sv
// One forward AES-128 key-expansion step: round key r-1 -> round key r.
// Combinational, zero latency.
// No flow control; ports: key_in, rcon (rcon[r]), key_out.
module key_schedule
    import aes_pkg::*;
(
    input  round_key_t  key_in,
    input  logic [31:0] rcon,
    output round_key_t  key_out
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = key_in[31:0];
    assign w1 = key_in[63:32];
    assign w2 = key_in[95:64];
    assign w3 = key_in[127:96];

    assign n0 = w0 ^ sub_word(rot_word(w3)) ^ rcon;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_out = {n3, n2, n1, n0};
endmodule

// File: rtl/key_schedule_rev.sv
// AES-128 decryption round-key generator: expands to round 10, then emits 10..0.
// Latency: rk_valid rises 10 cycles after key accept; 11 transfers at up to one per cycle.
// Backpressure: rk_ready low holds rk_data/rk_round; key_ready is high only in IDLE.
// Ports: clk, rst (async, active-high), bus (slave modport of key_schedule_rev_if).
module key_schedule_rev
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR  // only 10 (AES-128) is legal
) (
    input  logic              clk,
    input  logic              rst,
    key_schedule_rev_if.slave bus
);
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    ks_state_e  state_q, state_d;
    round_key_t key_q, key_d;
    logic [3:0] cnt_q, cnt_d;   // forward step index during EXPAND
    logic [3:0] rnd_q, rnd_d;   // index of the key held in key_q during EMIT

    round_key_t fwd_key;
    round_key_t inv_key;
    logic       emit;

    key_schedule u_fwd (
        .key_in  (key_q),
        .rcon    (rcon_of(cnt_q)),
        .key_out (fwd_key)
    );

    inv_key_step u_inv (
        .key_in  (key_q),
        .rcon    (rcon_of(rnd_q)),
        .key_out (inv_key)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    key_d   = bus.key_in;
                    cnt_d   = 4'd1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                key_d = fwd_key;
                if (cnt_q == LAST_RND) begin
                    cnt_d   = '0;
                    rnd_d   = LAST_RND;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (rnd_q != 4'd0) begin
                        // Step back one round; rcon index is that of the key leaving.
                        key_d = inv_key;
                        rnd_d = rnd_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign emit = (state_q == EMIT);

    assign bus.key_ready = (state_q == IDLE);
    assign bus.rk_valid  = emit;
    // Gated so the last round-0 key does not linger on the bus in IDLE.
    assign bus.rk_data   = emit ? key_q : '0;
    assign bus.rk_round  = rnd_q;
    assign bus.rk_last   = emit && (rnd_q == 4'd0);
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/key_schedule_rev.md
Name: key_schedule_rev

Overview:
Iterative AES-128 decryption round-key generator.
- Accepts the cipher key, then walks the forward schedule up to round key 10.
- Emits round keys 10, 9, …, 0, one per output handshake, by stepping the schedule backwards.
- Feeds the inverse-cipher datapath, which consumes round keys in reverse order; avoids an 11-entry key RAM.

Parameters:
NUM_ROUNDS, 10, number of rounds; only 10 (AES-128) is supported, other values are illegal.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
key_valid  input  1  cipher key offered
key_ready  output  1  block can accept a key (high only in IDLE)
key_in  input  128  cipher key; word i at [32i+31:32i], same packing as forward key_schedule
rk_valid  output  1  round key on rk_data is valid
rk_ready  input  1  consumer accepts round key
rk_data  output  128  current round key, same packing
rk_round  output  4  index of rk_data (10 down to 0)
rk_last  output  1  high when rk_round == 0 and rk_valid
busy  output  1  high in EXPAND or EMIT

Behaviour:
- Clock and reset: one clock clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, rk_valid=0, rk_data=0, rk_round=0, rk_last=0, busy=0, key_ready=1 once rst deasserts.
- Reset mid-operation: any state returns to IDLE immediately; the key in progress is discarded; no partial output.

State machine:
- IDLE:
  - key_ready=1.
  - key_valid&key_ready loads key_in into the key register, sets the counter to 1, goes to EXPAND.
- EXPAND:
  - Each cycle applies one forward step (key_schedule instance) with rcon[counter], then increments the counter.
  - After the step with counter=10 it goes to EMIT with rk_round=10.
  - Takes exactly 10 cycles.
- EMIT:
  - rk_valid=1, rk_data=key register.
  - On rk_valid&rk_ready with rk_round>0: the key register takes the inverse step using rcon[rk_round], and rk_round decrements.
  - rk_valid stays high, so back-to-back transfers run at one per cycle.
  - On the transfer with rk_round==0: go to IDLE, rk_valid=0, key_ready=1 in the next cycle.

Latency and handshake rules:
- Latency: key accepted at edge 0; rk_valid rises after edge 10 with round 10.
- With rk_ready held high, the last key (round 0) transfers 11 cycles later; total 21 cycles from key accept to IDLE.
- Once rk_valid is high, rk_data/rk_round/rk_last are stable while rk_ready=0; rk_valid never drops before its transfer.
- key_valid outside IDLE is ignored (key_ready=0). key_in is sampled only on its handshake.

Arithmetic:
- rcon[r] for r=1..10 is 01,02,04,08,10,20,40,80,1b,36, placed in the 32-bit rcon position the forward key_schedule uses.
- Inverse step, K' to K, with w'i words of K':
  - w3=w'3^w'2
  - w2=w'2^w'1
  - w1=w'1^w'0
  - w0=w'0^rcon[r]^SubWord(RotWord(w3))
  - Here r is the index of K'.
- Round 0 output must equal the loaded key_in bit-exactly.

Decomposition:
- Package aes_pkg:
  - AES_NR=10.
  - RCON constant array, 32-bit entries indexed 1..10.
  - State enum {IDLE, EXPAND, EMIT}.
  - 128-bit round-key typedef.
- Sub-module inv_key_step (combinational): 128-bit in, 32-bit rcon, 128-bit out. It reuses rot_word and sub_word.
- The forward step reuses the existing key_schedule instance; no new forward logic.

Test Plan:
- Reset then key 2b7e151628aed2a6abf7158809cf4f3c (FIPS-197 A.1, packed per codebase), rk_ready=1 -> rk_valid rises 10 cycles after accept. rk_round=10, rk_data=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same run, continued -> 11 consecutive transfers. Round 1 = a0fafe1788542cb123a339392a6c7605. Round 0 = key_in with rk_last=1. Then key_ready=1 the next cycle.
- rk_ready toggled pseudo-randomly during EMIT -> rk_data/rk_round held while stalled; the sequence is identical to the ungated run.
- key_valid pulsed with a different key during EXPAND and EMIT -> ignored, output sequence unchanged.
- rst asserted mid-EMIT at round 5 -> outputs go to reset values asynchronously. A new key afterwards produces a correct full sequence.
- All-zero key -> round 10 = b4ef5bcb3e92e21123e951cf6f8f188e, round 0 = 0; back-to-back second key accepted the cycle after IDLE.
